wb_data_ram: RTL and testbench

//  Wishbone B4 classic slave data memory; sits directly downstream of the LSU and serves its load/store cycles.

---
 rtl/wb_data_ram.sv | 163 ++++++++++++++++
 tb/tb_wb_data_ram.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_data_ram.sv
// Wishbone B4 classic slave data RAM with programmable wait states and byte-lane writes.
// Optional WB_RAM_MISALIGN_ERR_EN: misaligned half-word/word accesses terminate with err.
module wb_data_ram #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_1000),
  parameter int unsigned       WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [3:0]        wbs_sel_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              wbs_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WRD_W = ADDR_W - 2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_ack;
  logic               r_err;
  logic [31:0]        r_dat;
  logic               w_ack_nxt;
  logic               w_err_nxt;
  logic [31:0]        w_dat_nxt;
  logic               w_req;
  logic               w_mem_we;

  logic [IDX_W-1:0]   r_idx;
  logic               r_we;
  logic [31:0]        r_wdat;
  logic [3:0]         r_sel;
  logic               r_hit;
  logic               r_misal;

  logic [WRD_W-1:0]   w_off_word;
  logic               w_hit;
  logic               w_misal;
  logic [31:0]        w_mask;
  logic [31:0]        w_rd_word;

  logic [31:0]        r_mem [DEPTH_WORDS];

  // Word-granular decode; the full-address compare rejects anything below the window.
  assign w_off_word = wbs_adr_i[ADDR_W-1:2] - BASE_ADDR[ADDR_W-1:2];
  assign w_hit      = (wbs_adr_i >= BASE_ADDR) && (w_off_word[WRD_W-1:IDX_W] == '0);

`ifdef WB_RAM_MISALIGN_ERR_EN
  assign w_misal = ((wbs_sel_i == 4'b0011) && wbs_adr_i[0]) ||
                   ((wbs_sel_i == 4'b1111) && (wbs_adr_i[1:0] != 2'b00));
`else
  assign w_misal = 1'b0;
`endif

  assign w_mask    = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
  assign w_rd_word = r_mem[r_idx] & w_mask;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_dat   <= w_dat_nxt;
    end
  end

  // Request capture: later bus changes during the wait have no effect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdat  <= '0;
      r_sel   <= '0;
      r_hit   <= 1'b0;
      r_misal <= 1'b0;
    end else if (w_req) begin
      r_idx   <= w_off_word[IDX_W-1:0];
      r_we    <= wbs_we_i;
      r_wdat  <= wbs_dat_i;
      r_sel   <= wbs_sel_i;
      r_hit   <= w_hit;
      r_misal <= w_misal;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_dat_nxt   = '0;
    w_req       = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          w_req       = 1'b1;
          w_cnt_nxt   = CNT_W'(WAIT_STATES);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!(wbs_cyc_i && wbs_stb_i)) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = ST_RESP;
          if (r_hit && !r_misal) begin
            w_ack_nxt = 1'b1;
            w_mem_we  = r_we;
            if (!r_we) begin
              w_dat_nxt = w_rd_word;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Storage is not reset; writes commit on the edge entering RESP.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (r_sel[k]) begin
          r_mem[r_idx][8*k +: 8] <= r_wdat[8*k +: 8];
        end
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_wb_data_ram.sv
// Scoreboard bench for wb_data_ram: stimulus pushes expected terminations, a negedge monitor checks them.
module tb_wb_data_ram;

  localparam int unsigned WS = 1;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] cyc_cnt = 0;

  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
    logic [31:0] cyc;
  } exp_t;

  exp_t q[$];

  wb_data_ram #(
    .ADDR_W      (32),
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_1000),
    .WAIT_STATES (WS)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_sel_i (sel),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack),
    .wbs_err_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("ack_err_exclusive", {31'b0, ack & err}, 32'd0);
      if (ack || err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_termination actual ack=%b err=%b required=none", ack, err);
        end else begin
          e = q.pop_front();
          chk("term_is_err", {31'b0, err}, {31'b0, e.is_err});
          chk("term_cycle", cyc_cnt, e.cyc);
          if (e.chk_dat) chk("term_rdata", dat_o, e.dat);
        end
      end else begin
        chk("dat_zero_outside_resp", dat_o, 32'd0);
      end
    end
  end

  task automatic bus_idle();
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    adr   = 32'h0;
    dat_i = 32'h0;
    sel   = 4'h0;
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                     input logic [3:0] t_sel, input logic exp_err, input logic [31:0] exp_dat,
                     input logic scramble, input logic hold);
    exp_t e;
    logic got;
    e.is_err  = exp_err;
    e.chk_dat = exp_err | ~t_we;
    e.dat     = exp_err ? 32'h0 : exp_dat;
    e.cyc     = cyc_cnt + 2 + WS;
    q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; dat_i = t_dat; sel = t_sel;
    @(posedge clk); #1;
    if (scramble) begin
      adr = t_adr + 32'd4; dat_i = ~t_dat; sel = 4'b0000;
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack || err) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout actual=no_termination required=termination adr=%h", t_adr);
    end
    @(posedge clk); #1;
    if (!hold) bus_idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn(1'b1, a, d, s, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] s, input logic [31:0] exp_d);
    txn(1'b0, a, 32'h0, s, 1'b0, exp_d, 1'b0, 1'b0);
  endtask

  task automatic miss(input logic t_we, input logic [31:0] a, input logic [31:0] d);
    txn(t_we, a, d, 4'b1111, 1'b1, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'b0, ack}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_dat", dat_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic word write/read
    wr(32'h1000, 32'hDEADBEEF, 4'b1111);
    rd(32'h1000, 4'b1111, 32'hDEADBEEF);

    // Byte-lane write and lane-masked reads
    wr(32'h1004, 32'h11223344, 4'b1111);
    wr(32'h1004, 32'h000000AA, 4'b0001);
    rd(32'h1004, 4'b1111, 32'h112233AA);
    rd(32'h1004, 4'b0010, 32'h00003300);

    // sel=0000: ack, no write, zero read data
    wr(32'h1000, 32'hFFFFFFFF, 4'b0000);
    rd(32'h1000, 4'b0000, 32'h00000000);
    rd(32'h1000, 4'b1111, 32'hDEADBEEF);

    // Window boundaries
    miss(1'b0, 32'h0000_0FFC, 32'h0);
    miss(1'b0, 32'h0000_2000, 32'h0);
    wr(32'h1FFC, 32'h5A5A5A5A, 4'b1111);
    rd(32'h1FFC, 4'b1111, 32'h5A5A5A5A);
    miss(1'b1, 32'h0000_2000, 32'h0BADF00D);
    miss(1'b1, 32'h0000_0FFC, 32'hFFFFFFFF);
    rd(32'h1000, 4'b1111, 32'hDEADBEEF);
    rd(32'h1FFC, 4'b1111, 32'h5A5A5A5A);

    // Inputs changing during the wait are ignored
    wr(32'h100C, 32'h01020304, 4'b1111);
    txn(1'b1, 32'h1008, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0, 1'b1, 1'b0);
    rd(32'h1008, 4'b1111, 32'hCAFEF00D);
    rd(32'h100C, 4'b1111, 32'h01020304);

    // Back-to-back reads without an idle bus cycle
    txn(1'b0, 32'h1000, 32'h0, 4'b1111, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
    txn(1'b0, 32'h1004, 32'h0, 4'b1111, 1'b0, 32'h112233AA, 1'b0, 1'b0);

    // Abort after one wait cycle: no termination, no write
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1004; dat_i = 32'h99999999; sel = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_term", {30'b0, ack, err}, 32'd0);
    end
    @(posedge clk); #1;
    rd(32'h1004, 4'b1111, 32'h112233AA);

    // Reset just before the write would commit
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h1008; dat_i = 32'h55555555; sel = 4'b1111;
    @(posedge clk); #1;
    repeat (WS) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_wait_outputs", {dat_o[31:2], ack, err}, 32'd0);
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(32'h1008, 4'b1111, 32'hCAFEF00D);

    // Reset while ack is high clears outputs asynchronously
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h1000; dat_i = 32'h0; sel = 4'b1111;
    repeat (2 + WS) begin
      @(posedge clk); #1;
    end
    chk("resp_ack_before_rst", {31'b0, ack}, 32'd1);
    chk("resp_dat_before_rst", dat_o, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("rst_resp_ack", {31'b0, ack}, 32'd0);
    chk("rst_resp_err", {31'b0, err}, 32'd0);
    chk("rst_resp_dat", dat_o, 32'd0);
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Misaligned word store
`ifdef WB_RAM_MISALIGN_ERR_EN
    miss(1'b1, 32'h1002, 32'h12345678);
    rd(32'h1000, 4'b1111, 32'hDEADBEEF);
`else
    wr(32'h1002, 32'h12345678, 4'b1111);
    rd(32'h1000, 4'b1111, 32'h12345678);
`endif

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
